// File: rtl/fp16_operand_loader.sv
// fp16_operand_loader: captures fp16 operands/opcode for the FPU FSM and unpacks them to {sign, exp, mant}
module fp16_operand_loader #(
  parameter int OPW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic        ena_a,
  input  logic        ena_b,
  input  logic        ena_o,
  input  logic        clear,
  output logic [17:0] A,
  output logic [17:0] B,
  output logic [17:0] O,
  output logic [1:0]  a_class,
  output logic [1:0]  b_class,
  output logic        a_valid,
  output logic        b_valid,
  output logic        o_valid,
  output logic        o_err,
  output logic        ack,
  output logic        conflict,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LATCH, UNPACK, WAIT_REL} state_t;
  state_t      state;
  logic [15:0] raw_q;
  logic [1:0]  tgt;
  logic [4:0]  e;
  logic [9:0]  f;
  logic [17:0] unp;
  logic [1:0]  cls;
  logic        tgt_ena;
  logic        multi;
  always_comb begin
    e = raw_q[14:10];
    f = raw_q[9:0];
    unp = e == 5'd0 ? {raw_q[15], (f == 10'd0 ? 5'd0 : 5'd1), 2'b00, f} : {raw_q[15], e, 2'b01, f};
    cls = e == 5'd31 ? (f == 10'd0 ? 2'd2 : 2'd3) : (e == 5'd0 && f == 10'd0) ? 2'd1 : 2'd0;
    tgt_ena = tgt == 2'd0 ? ena_a : tgt == 2'd1 ? ena_b : ena_o;
    multi = (ena_a & ena_b) | (ena_a & ena_o) | (ena_b & ena_o);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      raw_q    <= '0;
      tgt      <= '0;
      A        <= '0;
      B        <= '0;
      O        <= '0;
      a_class  <= '0;
      b_class  <= '0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      ack      <= 1'b0;
      conflict <= 1'b0;
    end else if (clear) begin
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      o_valid  <= 1'b0;
      a_class  <= '0;
      b_class  <= '0;
      o_err    <= 1'b0;
      conflict <= 1'b0;
      ack      <= 1'b0;
      // a load already acknowledged must still see its ena released before the next one
      state    <= state == WAIT_REL ? WAIT_REL : IDLE;
    end else begin
      case (state)
        IDLE: if ((ena_a | ena_b | ena_o) & data_valid) begin
          raw_q    <= data_in;
          tgt      <= ena_a ? 2'd0 : ena_b ? 2'd1 : 2'd2;
          conflict <= conflict | multi;
          state    <= LATCH;
        end
        LATCH: state <= UNPACK;
        UNPACK: begin
          ack   <= 1'b1;
          state <= WAIT_REL;
          if (tgt == 2'd0) begin
            A       <= unp;
            a_class <= cls;
            a_valid <= 1'b1;
          end else if (tgt == 2'd1) begin
            B       <= unp;
            b_class <= cls;
            b_valid <= 1'b1;
          end else begin
            O       <= {{(18-OPW){1'b0}}, raw_q[OPW-1:0]};
            o_err   <= |raw_q[15:OPW];
            o_valid <= 1'b1;
          end
        end
        default: begin
          ack <= 1'b0;
          if (!tgt_ena) state <= IDLE;
        end
      endcase
    end
  end
endmodule
